// File: rtl/memory_access_if.sv
// memory_access_if: EX/MEM inputs, MEM/WB outputs and debug port of the memory stage
interface memory_access_if #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 7
);
  logic               i_enable;
  logic [NB_DATA-1:0] i_ALU_result;
  logic [NB_DATA-1:0] i_data_to_write_in_MEM;
  logic [4:0]         i_write_reg;
  logic               i_WB_write;
  logic               i_WB_mem_to_reg;
  logic               i_MEM_read;
  logic               i_MEM_write;
  logic               i_MEM_unsigned;
  logic [1:0]         i_MEM_byte_half_word;
  logic [NB_ADDR-1:0] i_debug_addr;
  logic               o_WB_write;
  logic               o_WB_mem_to_reg;
  logic [4:0]         o_write_reg;
  logic [NB_DATA-1:0] o_ALU_result;
  logic [NB_DATA-1:0] o_read_data;
  logic               o_misaligned;
  logic [NB_DATA-1:0] o_debug_data;
  modport slave (
    input  i_enable, i_ALU_result, i_data_to_write_in_MEM, i_write_reg, i_WB_write,
           i_WB_mem_to_reg, i_MEM_read, i_MEM_write, i_MEM_unsigned, i_MEM_byte_half_word,
           i_debug_addr,
    output o_WB_write, o_WB_mem_to_reg, o_write_reg, o_ALU_result, o_read_data,
           o_misaligned, o_debug_data
  );
  modport master (
    output i_enable, i_ALU_result, i_data_to_write_in_MEM, i_write_reg, i_WB_write,
           i_WB_mem_to_reg, i_MEM_read, i_MEM_write, i_MEM_unsigned, i_MEM_byte_half_word,
           i_debug_addr,
    input  o_WB_write, o_WB_mem_to_reg, o_write_reg, o_ALU_result, o_read_data,
           o_misaligned, o_debug_data
  );
endinterface

// File: rtl/memory_access.sv
// memory_access: MIPS MEM stage with byte-lane data memory, extended loads and MEM/WB register
module memory_access #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 7
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  memory_access_if.slave   bus
);
  logic [NB_DATA-1:0] r_mem [2**NB_ADDR];
  logic               r_WB_write;
  logic               r_WB_mem_to_reg;
  logic [4:0]         r_write_reg;
  logic [NB_DATA-1:0] r_ALU_result;
  logic [NB_DATA-1:0] r_read_data;
  logic               r_misaligned;
  logic [NB_ADDR-1:0] w_idx;
  logic [1:0]         w_off;
  logic [1:0]         w_bhw;
  logic               w_misaligned;
  logic               w_store;
  logic               w_load;
  logic [NB_DATA-1:0] w_rd_word;
  logic [NB_DATA-1:0] w_lane;
  logic [NB_DATA-1:0] w_load_ext;
  logic [NB_DATA-1:0] w_wdata;
  logic [3:0]         w_be;
  assign w_idx   = bus.i_ALU_result[NB_ADDR+1:2];
  assign w_off   = bus.i_ALU_result[1:0];
  assign w_bhw   = bus.i_MEM_byte_half_word;
  // Byte is always aligned; half needs an even offset; word (and the 10 encoding) needs offset 0
  assign w_misaligned = (bus.i_MEM_read || bus.i_MEM_write) &&
                        ((w_bhw == 2'b01 && w_off[0]) || (w_bhw[1] && w_off != 2'b00));
  assign w_store = bus.i_MEM_write && !w_misaligned;
  assign w_load  = bus.i_MEM_read && !bus.i_MEM_write;
  assign w_rd_word = r_mem[w_idx];
  assign w_lane    = w_rd_word >> {w_off, 3'b000};
  assign w_load_ext = w_bhw == 2'b00 ? {{24{~bus.i_MEM_unsigned & w_lane[7]}}, w_lane[7:0]} :
                      w_bhw == 2'b01 ? {{16{~bus.i_MEM_unsigned & w_lane[15]}}, w_lane[15:0]} :
                      w_lane;
  assign w_wdata = w_bhw == 2'b00 ? {4{bus.i_data_to_write_in_MEM[7:0]}} :
                   w_bhw == 2'b01 ? {2{bus.i_data_to_write_in_MEM[15:0]}} :
                   bus.i_data_to_write_in_MEM;
  assign w_be    = w_bhw == 2'b00 ? 4'b0001 << w_off :
                   w_bhw == 2'b01 ? 4'b0011 << w_off : 4'b1111;
  // Data memory: cleared on reset, lane-masked store on enabled aligned writes
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int k = 0; k < 2**NB_ADDR; k++) r_mem[k] <= '0;
    end else if (bus.i_enable && w_store) begin
      for (int b = 0; b < 4; b++) if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
    end
  end
  // MEM/WB pipeline register; a misaligned load cancels its register write-back
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_WB_write      <= 1'b0;
      r_WB_mem_to_reg <= 1'b0;
      r_write_reg     <= '0;
      r_ALU_result    <= '0;
      r_read_data     <= '0;
      r_misaligned    <= 1'b0;
    end else if (bus.i_enable) begin
      r_WB_write      <= bus.i_WB_write && !(w_load && w_misaligned);
      r_WB_mem_to_reg <= bus.i_WB_mem_to_reg;
      r_write_reg     <= bus.i_write_reg;
      r_ALU_result    <= bus.i_ALU_result;
      r_read_data     <= (w_load && !w_misaligned) ? w_load_ext : '0;
      r_misaligned    <= w_misaligned;
    end
  end
  assign bus.o_WB_write      = r_WB_write;
  assign bus.o_WB_mem_to_reg = r_WB_mem_to_reg;
  assign bus.o_write_reg     = r_write_reg;
  assign bus.o_ALU_result    = r_ALU_result;
  assign bus.o_read_data     = r_read_data;
  assign bus.o_misaligned    = r_misaligned;
  assign bus.o_debug_data    = r_mem[bus.i_debug_addr];
endmodule

// File: tb/tb_memory_access.sv
// tb_memory_access: directed vector table plus debug-port and async-reset sequences
module tb_memory_access;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  memory_access_if #(.NB_DATA(32), .NB_ADDR(7)) bus ();
  memory_access #(.NB_DATA(32), .NB_ADDR(7)) dut (.i_clk(clk), .i_reset_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic        en, rd, wr, uns;
    logic [1:0]  bhw;
    logic [31:0] addr, data;
    logic [31:0] exp_rd;
    logic        exp_mis, exp_wbw;
    logic [31:0] exp_alu;
    logic [6:0]  dbg;
    logic [31:0] exp_dbg;
  } vec_t;
  vec_t vecs [26];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic drive(input vec_t v, input int idx);
    bus.i_enable               = v.en;
    bus.i_ALU_result           = v.addr;
    bus.i_data_to_write_in_MEM = v.data;
    bus.i_write_reg            = idx[4:0];
    bus.i_WB_write             = 1'b1;
    bus.i_WB_mem_to_reg        = ~v.rd;
    bus.i_MEM_read             = v.rd;
    bus.i_MEM_write            = v.wr;
    bus.i_MEM_unsigned         = v.uns;
    bus.i_MEM_byte_half_word   = v.bhw;
  endtask
  task automatic chk_outs_zero(input string tag);
    chk({tag, " wbw"}, {31'd0, bus.o_WB_write}, 32'd0);
    chk({tag, " m2r"}, {31'd0, bus.o_WB_mem_to_reg}, 32'd0);
    chk({tag, " wreg"}, {27'd0, bus.o_write_reg}, 32'd0);
    chk({tag, " alu"}, bus.o_ALU_result, 32'd0);
    chk({tag, " rdata"}, bus.o_read_data, 32'd0);
    chk({tag, " mis"}, {31'd0, bus.o_misaligned}, 32'd0);
  endtask
  initial begin
    int last;
    int zero_bad;
    vec_t v;
    //          en rd wr us bhw    addr          data          exp_rd        mis wbw exp_alu       dbg  exp_dbg
    vecs[0]  = '{1, 0, 1, 0, 2'b11, 32'h10,  32'h12345678, 32'h0,        0, 1, 32'h10,  7'd4, 32'h12345678};
    vecs[1]  = '{1, 1, 0, 0, 2'b11, 32'h10,  32'h0,        32'h12345678, 0, 1, 32'h10,  7'd4, 32'h12345678};
    vecs[2]  = '{1, 0, 1, 0, 2'b00, 32'h12,  32'h000000AB, 32'h0,        0, 1, 32'h12,  7'd4, 32'h12AB5678};
    vecs[3]  = '{1, 1, 0, 1, 2'b00, 32'h12,  32'h0,        32'h000000AB, 0, 1, 32'h12,  7'd4, 32'h12AB5678};
    vecs[4]  = '{1, 1, 0, 0, 2'b00, 32'h12,  32'h0,        32'hFFFFFFAB, 0, 1, 32'h12,  7'd4, 32'h12AB5678};
    vecs[5]  = '{1, 1, 0, 0, 2'b11, 32'h10,  32'h0,        32'h12AB5678, 0, 1, 32'h10,  7'd4, 32'h12AB5678};
    vecs[6]  = '{1, 0, 1, 0, 2'b01, 32'h16,  32'h00008001, 32'h0,        0, 1, 32'h16,  7'd5, 32'h80010000};
    vecs[7]  = '{1, 1, 0, 0, 2'b01, 32'h16,  32'h0,        32'hFFFF8001, 0, 1, 32'h16,  7'd5, 32'h80010000};
    vecs[8]  = '{1, 1, 0, 1, 2'b01, 32'h16,  32'h0,        32'h00008001, 0, 1, 32'h16,  7'd5, 32'h80010000};
    vecs[9]  = '{1, 1, 0, 0, 2'b11, 32'h14,  32'h0,        32'h80010000, 0, 1, 32'h14,  7'd5, 32'h80010000};
    vecs[10] = '{1, 1, 0, 0, 2'b11, 32'h11,  32'h0,        32'h0,        1, 0, 32'h11,  7'd4, 32'h12AB5678};
    vecs[11] = '{1, 0, 1, 0, 2'b01, 32'h13,  32'h0000BEEF, 32'h0,        1, 1, 32'h13,  7'd4, 32'h12AB5678};
    vecs[12] = '{1, 1, 0, 0, 2'b11, 32'h10,  32'h0,        32'h12AB5678, 0, 1, 32'h10,  7'd4, 32'h12AB5678};
    vecs[13] = '{0, 0, 1, 0, 2'b11, 32'h20,  32'h11111111, 32'h12AB5678, 0, 1, 32'h10,  7'd8, 32'h0};
    vecs[14] = '{1, 1, 0, 0, 2'b11, 32'h20,  32'h0,        32'h0,        0, 1, 32'h20,  7'd8, 32'h0};
    vecs[15] = '{1, 0, 1, 0, 2'b11, 32'h220, 32'hCAFEF00D, 32'h0,        0, 1, 32'h220, 7'd8, 32'hCAFEF00D};
    vecs[16] = '{1, 1, 0, 0, 2'b11, 32'h20,  32'h0,        32'hCAFEF00D, 0, 1, 32'h20,  7'd8, 32'hCAFEF00D};
    vecs[17] = '{1, 1, 0, 1, 2'b00, 32'h23,  32'h0,        32'h000000CA, 0, 1, 32'h23,  7'd8, 32'hCAFEF00D};
    vecs[18] = '{1, 1, 0, 0, 2'b00, 32'h23,  32'h0,        32'hFFFFFFCA, 0, 1, 32'h23,  7'd8, 32'hCAFEF00D};
    vecs[19] = '{1, 1, 1, 0, 2'b00, 32'h21,  32'h00000080, 32'h0,        0, 1, 32'h21,  7'd8, 32'hCAFE800D};
    vecs[20] = '{1, 1, 0, 0, 2'b00, 32'h21,  32'h0,        32'hFFFFFF80, 0, 1, 32'h21,  7'd8, 32'hCAFE800D};
    vecs[21] = '{1, 1, 0, 1, 2'b00, 32'h21,  32'h0,        32'h00000080, 0, 1, 32'h21,  7'd8, 32'hCAFE800D};
    vecs[22] = '{1, 1, 0, 0, 2'b10, 32'h20,  32'h0,        32'hCAFE800D, 0, 1, 32'h20,  7'd8, 32'hCAFE800D};
    vecs[23] = '{1, 1, 0, 0, 2'b11, 32'h22,  32'h0,        32'h0,        1, 0, 32'h22,  7'd8, 32'hCAFE800D};
    vecs[24] = '{1, 1, 0, 0, 2'b01, 32'h22,  32'h0,        32'hFFFFCAFE, 0, 1, 32'h22,  7'd8, 32'hCAFE800D};
    vecs[25] = '{1, 0, 0, 0, 2'b11, 32'h7,   32'h0,        32'h0,        0, 1, 32'h7,   7'd8, 32'hCAFE800D};
    v = vecs[25];
    drive(v, 0);
    bus.i_enable = 1'b0;
    bus.i_debug_addr = 7'd4;
    repeat (2) @(posedge clk);
    #1;
    chk_outs_zero("reset");
    chk("reset dbg", bus.o_debug_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    last = 0;
    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      drive(vecs[i], i);
      @(posedge clk);
      #1;
      if (vecs[i].en) last = i;
      chk($sformatf("v%0d rdata", i), bus.o_read_data, vecs[i].exp_rd);
      chk($sformatf("v%0d mis", i), {31'd0, bus.o_misaligned}, {31'd0, vecs[i].exp_mis});
      chk($sformatf("v%0d wbw", i), {31'd0, bus.o_WB_write}, {31'd0, vecs[i].exp_wbw});
      chk($sformatf("v%0d alu", i), bus.o_ALU_result, vecs[i].exp_alu);
      chk($sformatf("v%0d wreg", i), {27'd0, bus.o_write_reg}, last);
      chk($sformatf("v%0d m2r", i), {31'd0, bus.o_WB_mem_to_reg}, {31'd0, ~vecs[last].rd});
      bus.i_debug_addr = vecs[i].dbg;
      #1;
      chk($sformatf("v%0d dbg", i), bus.o_debug_data, vecs[i].exp_dbg);
    end
    @(negedge clk);
    v = '{1, 0, 1, 0, 2'b11, 32'h24, 32'h55AA55AA, 32'h0, 0, 1, 32'h24, 7'd9, 32'h55AA55AA};
    drive(v, 3);
    bus.i_debug_addr = 7'd9;
    #1;
    chk("same-edge old", bus.o_debug_data, 32'd0);
    @(posedge clk);
    #1;
    chk("same-edge new", bus.o_debug_data, 32'h55AA55AA);
    @(negedge clk);
    v = '{1, 0, 1, 0, 2'b11, 32'h28, 32'h77777777, 32'h0, 0, 1, 32'h28, 7'd10, 32'h0};
    drive(v, 7);
    #2;
    rst_n = 1'b0;
    #1;
    chk_outs_zero("async rst");
    zero_bad = 0;
    for (int k = 0; k < 128; k++) begin
      bus.i_debug_addr = k[6:0];
      #0.01;
      if (bus.o_debug_data !== 32'd0) zero_bad++;
    end
    chk("rst mem nonzero words", zero_bad, 0);
    @(posedge clk);
    #1;
    bus.i_debug_addr = 7'd10;
    #1;
    chk("rst inflight store", bus.o_debug_data, 32'd0);
    chk_outs_zero("rst held");
    @(negedge clk);
    rst_n = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
